// File: rtl/interval_sequencer_if.sv
// ============================================================================
//  interval_sequencer_if
//  Pattern-programming, control and status bundle of interval_sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface interval_sequencer_if #(
    parameter int AW = 3
);
    logic          tick;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic [AW-1:0] last_idx;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic          busy;
    logic          step_pulse;
    logic [AW-1:0] step_idx;
    logic [3:0]    remaining;
    logic          done_pulse;

    modport master (
        output tick, wr_en, wr_addr, wr_data, last_idx, loop_en, start, stop,
        input  busy, step_pulse, step_idx, remaining, done_pulse
    );

    modport slave (
        input  tick, wr_en, wr_addr, wr_data, last_idx, loop_en, start, stop,
        output busy, step_pulse, step_idx, remaining, done_pulse
    );
endinterface

`default_nettype wire

// File: rtl/interval_sequencer.sv
// ============================================================================
//  interval_sequencer
//  Steps one shared 4-bit down-counter through a programmable interval pattern.
//  Option: INTERVAL_SEQ_TICK_EDGE_EN -> tick synchronised, counted per rising edge.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module interval_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    interval_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COUNT = 3'd2,
        S_FIRE  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_step_idx;
    logic [AW-1:0] r_last_idx;
    logic [3:0]    r_remaining;
    logic          r_step_pulse;
    logic          r_done_pulse;
    logic          w_tick;

`ifdef INTERVAL_SEQ_TICK_EDGE_EN
    logic r_tick_s1;
    logic r_tick_s2;
    logic r_tick_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tick_s1 <= 1'b0;
            r_tick_s2 <= 1'b0;
            r_tick_d  <= 1'b0;
        end else begin
            r_tick_s1 <= bus.tick;
            r_tick_s2 <= r_tick_s1;
            r_tick_d  <= r_tick_s2;
        end
    end

    assign w_tick = r_tick_s2 & ~r_tick_d;
`else
    assign w_tick = bus.tick;
`endif

    // Writes land at the edge, so a LOAD in the same cycle still sees the old entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 4'd0;
            end
        end else if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_step_idx   <= '0;
            r_last_idx   <= '0;
            r_remaining  <= 4'd0;
            r_step_pulse <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            r_done_pulse <= 1'b0;
            if (bus.stop && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_step_idx  <= '0;
                r_remaining <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            r_state    <= S_LOAD;
                            r_step_idx <= '0;
                            r_last_idx <= bus.last_idx;
                        end
                    end
                    S_LOAD: begin
                        r_remaining <= r_mem[r_step_idx];
                        r_state     <= S_COUNT;
                    end
                    S_COUNT: begin
                        // Zero is acted on one cycle after the decrement that produced it.
                        if (r_remaining == 4'd0) begin
                            r_state      <= S_FIRE;
                            r_step_pulse <= 1'b1;
                        end else if (w_tick) begin
                            r_remaining <= r_remaining - 4'd1;
                        end
                    end
                    S_FIRE: begin
                        if (r_step_idx != r_last_idx) begin
                            r_step_idx <= r_step_idx + AW'(1);
                            r_state    <= S_LOAD;
                        end else if (bus.loop_en) begin
                            r_step_idx <= '0;
                            r_state    <= S_LOAD;
                        end else begin
                            r_state      <= S_DONE;
                            r_done_pulse <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state    <= S_IDLE;
                        r_step_idx <= '0;
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_step_idx <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.step_pulse = r_step_pulse;
    assign bus.done_pulse = r_done_pulse;
    assign bus.step_idx   = r_step_idx;
    assign bus.remaining  = r_remaining;

endmodule

`default_nettype wire

// File: doc/interval_sequencer.md
Name: interval_sequencer

Overview:
- Sequences a single shared 4-bit interval down-counter through a programmable pattern of up to DEPTH intervals.
- Each interval is counted in tick strobes. When an interval elapses, the block emits a one-cycle step_pulse and loads the next entry.
- After the last entry it either loops or finishes with done_pulse.
- Sits between the tempo/tick source and the per-step consumers (sound/display triggers). It replaces ad-hoc chaining of individual counters.

Parameters:
DEPTH, 8, number of pattern entries (power of two, 2..16)
AW, 3, address width = log2(DEPTH)

Ports:
clock  input  1  system clock; all state changes on rising edge
resetn  input  1  asynchronous, active-low reset
tick  input  1  count strobe; one count per clock cycle in which tick=1 (see Optional Feature)
wr_en  input  1  pattern write enable
wr_addr  input  AW  pattern entry address
wr_data  input  4  interval value in ticks (0..15)
last_idx  input  AW  index of final pattern entry; latched at start
loop_en  input  1  1 = restart at entry 0 after last entry; sampled in FIRE
start  input  1  begin sequence; honoured only in IDLE
stop  input  1  abort sequence; synchronous
busy  output  1  1 in any state other than IDLE
step_pulse  output  1  one-cycle pulse when the current interval elapses
step_idx  output  AW  index of entry currently loaded or counted
remaining  output  4  ticks left in current interval
done_pulse  output  1  one-cycle pulse when a non-looping sequence completes

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE; step_idx=0, remaining=0; busy, step_pulse and done_pulse all 0.
  - Latched last_idx=0; all pattern entries cleared to 0.
- States: IDLE, LOAD, COUNT, FIRE, DONE. step_pulse=1 only in FIRE; done_pulse=1 only in DONE; busy=(state!=IDLE). All outputs are registered or decoded from registered state.
- IDLE:
  - start=1 and stop=0 -> LOAD; step_idx<=0; latch last_idx.
  - start and stop both 1 -> stay IDLE.
- LOAD: remaining<=mem[step_idx]; -> COUNT (one cycle).
- COUNT:
  - remaining==0 -> FIRE.
  - Otherwise tick=1 decrements remaining; the decrement reaching 0 is seen the next cycle and leads to FIRE.
  - Latency from start to first step_pulse with interval N and tick held 1: N+3 cycles. Interval 0 fires 3 cycles after start, with no ticks required.
- FIRE:
  - step_idx!=latched last_idx -> step_idx+1, go to LOAD.
  - step_idx==last_idx and loop_en=1 -> step_idx<=0, go to LOAD.
  - step_idx==last_idx and loop_en=0 -> DONE.
- DONE: -> IDLE; step_idx<=0.
- Ticks arriving in LOAD, FIRE or DONE are ignored; they are not queued.
- Pattern writes:
  - Accepted in any state.
  - A write in the same cycle as LOAD to the same address: LOAD reads the old value.
  - A write to an entry not yet loaded takes effect when that entry is loaded.
- stop=1 in any non-IDLE state -> IDLE next cycle; step_idx<=0, remaining<=0; no step_pulse or done_pulse is emitted. stop has priority over every other transition.
- last_idx changes during a run have no effect until the next start.
- Arithmetic: remaining is 4-bit unsigned; it never decrements below 0. Index increment wraps modulo DEPTH, though it is bounded by last_idx.
- start while busy is ignored (no restart).

Optional Feature:
- Macro: INTERVAL_SEQ_TICK_EDGE_EN.
- Defined:
  - tick passes through a 2-flop synchronizer plus a rising-edge detector.
  - One count per 0->1 transition of tick; a held-high tick counts once.
  - Adds 2 cycles of latency from the tick edge to the remaining decrement.
  - Synchronizer flops reset to 0.
- Undefined: tick is used directly as a level strobe; each cycle with tick=1 counts.

Test Plan:
- Reset and program pattern:
  - Assert resetn=0 mid-COUNT -> all outputs 0 immediately, state IDLE.
  - Write entries {3,1,2}, last_idx=2, loop_en=0, start, tick=1 continuous -> step_pulse at cycles 6, 10, 15 after start; done_pulse at cycle 16; busy low at cycle 17.
- Zero interval: entry0=0, last_idx=0, loop_en=0, tick=0 -> step_pulse at cycle 3, done_pulse at cycle 4, remaining stays 0.
- Looping: entries {2,2}, last_idx=1, loop_en=1, tick every cycle -> step_pulse every 5 cycles with step_idx 0,1,0,1; no done_pulse. Drop loop_en -> done_pulse after next step 1.
- Stop and collisions:
  - Entry 5, tick=1, stop at remaining=2 -> IDLE next cycle, no step_pulse, step_idx=0.
  - start+stop together in IDLE -> stays IDLE.
- Write collisions: write entry1=9 in the same cycle LOAD reads entry1 (old=4) -> remaining loads 4. Write entry2=7 during entry0 count -> entry2 later loads 7.
- With INTERVAL_SEQ_TICK_EDGE_EN: entry 2, tick held high 10 cycles -> remaining 2->1 only, no step_pulse. Two separate 1-cycle tick pulses -> step_pulse.
